// File: rtl/vec_logger.sv
// Self-test response logger: captures {A,B,Y} tuples with a mismatch flag,
// then streams them out over a valid/ready port in capture order.
module vec_logger #(
  parameter  int AW    = 8,
  parameter  int BW    = 4,
  parameter  int YW    = 8,
  parameter  int DEPTH = 16,
  localparam int RW    = AW + BW + YW + 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          cap_en,
  input  logic [AW-1:0] a_in,
  input  logic [BW-1:0] b_in,
  input  logic [YW-1:0] y_in,
  input  logic [YW-1:0] y_exp,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [RW-1:0] rd_data,
  output logic          rd_last,
  output logic [CW-1:0] count,
  output logic [15:0]   err_count,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] mem [DEPTH];
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] rd_nxt;
  logic          mm;
  logic          capture;

  assign mm      = (y_in != y_exp);
  assign capture = (state_q == ST_CAPTURE) && cap_en;
  assign rd_nxt  = rd_ptr + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cap_en && count == LAST_SLOT)
          state_d = ST_DRAIN;
        else if (stop)
          state_d = (cap_en || count != '0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        if (rd_valid && rd_ready && rd_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // count doubles as the write pointer: it never reaches DEPTH while capturing
  always_ff @(posedge clk) begin
    if (capture) mem[count[IW-1:0]] <= {mm, a_in, b_in, y_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      err_count <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count     <= '0;
            err_count <= '0;
            rd_ptr    <= '0;
          end
        end
        ST_CAPTURE: begin
          if (cap_en) begin
            count <= count + CW'(1);
            if (mm && err_count != '1) err_count <= err_count + 16'd1;
          end
        end
        ST_DRAIN: begin
          // Output stage is registered: the first record is loaded on the
          // cycle after entry, then refilled back-to-back on each transfer.
          if (!rd_valid) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_ptr[IW-1:0]];
            rd_last  <= (rd_ptr == count - CW'(1));
          end else if (rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else begin
              rd_ptr  <= rd_nxt;
              rd_data <= mem[rd_nxt[IW-1:0]];
              rd_last <= (rd_nxt == count - CW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
